// File: rtl/uart_host_link.sv
// Host-side UART link endpoint: ships a 32-bit instruction as four 8N1 bytes,
// then gathers the 128-byte register-file dump returned by the processor board.
module uart_host_link #(
    parameter int CLKS_PER_BIT   = 104,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inst_valid,
    output logic          inst_ready,
    input  logic [31:0]   inst_data,
    output logic          tx,
    input  logic          rx,
    output logic [1023:0] regfile,
    output logic          regfile_valid,
    output logic          busy,
    output logic          error
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

    state_t              state, state_next;
    logic [31:0]         inst_q;
    logic [6:0]          byte_cnt;
    logic [BAUD_W-1:0]   tx_baud;
    logic [3:0]          tx_bit;
    logic [7:0]          tx_byte;
    logic [TO_W-1:0]     timeout_cnt;
    logic [1023:0]       shadow;

    logic                rx_p0, rx_p1, rx_prev;
    logic                rx_active;
    logic [BAUD_W-1:0]   rx_baud;
    logic [3:0]          rx_bit;
    logic [7:0]          rx_shift;

    logic rx_tick, rx_stop, byte_done, frame_bad, send_last, timeout_hit;

    // bit 0 is the start-bit recheck at half a bit; later bits land on centres
    assign rx_tick     = rx_active && (rx_baud == ((rx_bit == 4'd0) ? BAUD_HALF : BAUD_LAST));
    assign rx_stop     = rx_tick && (rx_bit == 4'd9);
    assign byte_done   = rx_stop && rx_p1;
    assign frame_bad   = rx_stop && !rx_p1;
    assign send_last   = (tx_baud == BAUD_LAST) && (tx_bit == 4'd9) && (byte_cnt[1:0] == 2'd3);
    assign timeout_hit = timeout_cnt >= TO_LIMIT;

    assign inst_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign tx_byte    = inst_q[{byte_cnt[1:0], 3'b000} +: 8];

    always_comb begin
        tx = 1'b1;
        if (state == SEND) begin
            case (tx_bit)
                4'd0:    tx = 1'b0;
                4'd9:    tx = 1'b1;
                default: tx = tx_byte[3'(tx_bit - 4'd1)];
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (inst_valid) state_next = SEND;
            SEND: if (send_last) state_next = RECV;
            RECV: begin
                if (frame_bad || timeout_hit)
                    state_next = IDLE;
                else if (byte_done && byte_cnt == 7'd127)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Synchroniser and receiver; sync flops clear low so a line held low
    // through reset cannot fake a start edge until it has been seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_p0     <= 1'b0;
            rx_p1     <= 1'b0;
            rx_prev   <= 1'b0;
            rx_active <= 1'b0;
            rx_baud   <= '0;
            rx_bit    <= 4'd0;
            rx_shift  <= 8'd0;
        end else begin
            rx_p0   <= rx;
            rx_p1   <= rx_p0;
            rx_prev <= rx_p1;
            if (!rx_active) begin
                if (rx_prev && !rx_p1) begin
                    rx_active <= 1'b1;
                    rx_baud   <= '0;
                    rx_bit    <= 4'd0;
                end
            end else if (rx_tick) begin
                rx_baud <= '0;
                if (rx_bit == 4'd0) begin
                    if (rx_p1) rx_active <= 1'b0;
                    else       rx_bit    <= 4'd1;
                end else if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                end else begin
                    rx_shift <= {rx_p1, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 4'd1;
                end
            end else begin
                rx_baud <= rx_baud + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            inst_q        <= 32'd0;
            byte_cnt      <= 7'd0;
            tx_baud       <= '0;
            tx_bit        <= 4'd0;
            timeout_cnt   <= '0;
            shadow        <= '0;
            regfile       <= '0;
            regfile_valid <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_next;
            regfile_valid <= 1'b0;
            error         <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_valid) begin
                        inst_q   <= inst_data;
                        byte_cnt <= 7'd0;
                        tx_baud  <= '0;
                        tx_bit   <= 4'd0;
                    end
                end
                SEND: begin
                    if (tx_baud == BAUD_LAST) begin
                        tx_baud <= '0;
                        if (tx_bit == 4'd9) begin
                            tx_bit <= 4'd0;
                            if (byte_cnt[1:0] == 2'd3) begin
                                byte_cnt    <= 7'd0;
                                timeout_cnt <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + 7'd1;
                            end
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                RECV: begin
                    if (frame_bad || timeout_hit) begin
                        error <= 1'b1;
                    end else if (byte_done) begin
                        shadow[{byte_cnt, 3'b000} +: 8] <= rx_shift;
                        byte_cnt    <= byte_cnt + 7'd1;
                        timeout_cnt <= '0;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                DONE: begin
                    regfile       <= shadow;
                    regfile_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
